// File: rtl/sap_core_param.sv
// Parametrised accumulator computer: internal RAM, load port, multi-cycle FSM
// and a ready/valid output port with backpressure.
module sap_core_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic              cf,
   output logic              zf
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpLdi = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpJz  = 4'h8;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StOutwait,
      StHalt
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic                cf_q, cf_d;
   logic                zf_q, zf_d;
   logic                outv_q, outv_d;
   logic [DATA_W-1:0]   outd_q, outd_d;

   logic [DATA_W-1:0]   ram [Depth];
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;

   logic [3:0]          opcode;
   logic [ADDR_W-1:0]   operand;
   logic [DATA_W-1:0]   mem_rd;
   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   diff;

   assign opcode  = ir_q[DATA_W-1 -: 4];
   assign operand = ir_q[ADDR_W-1:0];
   assign mem_rd  = ram[operand];
   assign sum     = {1'b0, a_q} + {1'b0, mem_rd};
   assign diff    = a_q - mem_rd;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      a_d       = a_q;
      ir_d      = ir_q;
      cf_d      = cf_q;
      zf_d      = zf_q;
      outv_d    = outv_q;
      outd_d    = outd_q;
      ram_we    = 1'b0;
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
      unique case (state_q)
         StIdle, StHalt: begin
            // A load in the same cycle as run wins; run is dropped.
            if (ld_valid) begin
               ram_we = 1'b1;
            end else if (run) begin
               pc_d    = '0;
               a_d     = '0;
               cf_d    = 1'b0;
               zf_d    = 1'b0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            ir_d    = ram[pc_q];
            pc_d    = pc_q + 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            state_d = StFetch;
            case (opcode)
               OpLda, OpAdd, OpSub: state_d = StExec;
               OpSta: begin
                  ram_we    = 1'b1;
                  ram_waddr = operand;
                  ram_wdata = a_q;
               end
               OpLdi: a_d = {{(DATA_W - ADDR_W){1'b0}}, operand};
               OpJmp: pc_d = operand;
               OpJc:  if (cf_q) pc_d = operand;
               OpJz:  if (zf_q) pc_d = operand;
               OpOut: begin
                  outd_d  = a_q;
                  outv_d  = 1'b1;
                  state_d = StOutwait;
               end
               OpHlt: state_d = StHalt;
               default: ;
            endcase
         end
         StExec: begin
            state_d = StFetch;
            case (opcode)
               OpLda: a_d = mem_rd;
               OpAdd: begin
                  {cf_d, a_d} = sum;
                  zf_d        = (sum[DATA_W-1:0] == '0);
               end
               OpSub: begin
                  a_d  = diff;
                  cf_d = (a_q >= mem_rd);
                  zf_d = (diff == '0);
               end
               default: ;
            endcase
         end
         StOutwait: begin
            if (out_ready) begin
               outv_d  = 1'b0;
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
         pc_q    <= '0;
         a_q     <= '0;
         ir_q    <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         outv_q  <= 1'b0;
         outd_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         ir_q    <= ir_d;
         cf_q    <= cf_d;
         zf_q    <= zf_d;
         outv_q  <= outv_d;
         outd_q  <= outd_d;
      end
   end

   // RAM has no reset so program contents survive clr.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
   end

   assign ld_ready  = (state_q == StIdle) || (state_q == StHalt);
   assign halted    = (state_q == StHalt);
   assign out_valid = outv_q;
   assign out_data  = outd_q;
   assign pc        = pc_q;
   assign cf        = cf_q;
   assign zf        = zf_q;

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: directed program table, random programs against an
// instruction-level model, and an asynchronous reset during an output stall.
module tb_sap_core_param;

   logic       clk = 1'b0;
   logic       clr;
   logic       run;
   logic       ld_valid;
   logic       ld_ready;
   logic [3:0] ld_addr;
   logic [7:0] ld_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       halted;
   logic [3:0] pc;
   logic       cf;
   logic       zf;

   sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .halted    (halted),
      .pc        (pc),
      .cf        (cf),
      .zf        (zf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] prog;   // word i at bits [i*8 +: 8]
      int           stall;
      int           inject; // cycle of a mid-run load attempt, -1 for none
      int           chk_wrap;
      int           n_out;
      int           out0;
      int           out1;
      int           pc;
      int           cf;
      int           zf;
      int           cycles;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   int got_outs[$];
   int run_cycles;
   int wrapped;

   int m_ram[16];
   int m_outs[$];
   int m_pc, m_cf, m_zf, m_cycles, m_halted;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic load_word(input int a, input int d);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = 4'(a);
      ld_data  = 8'(d);
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   // Instruction-level interpreter; cycle cost per instruction class.
   task automatic model_run(input int stall);
      int mem[16];
      int p, a, c, z, ir, opc, op, steps, s;
      for (int i = 0; i < 16; i++) mem[i] = m_ram[i];
      p = 0; a = 0; c = 0; z = 0; steps = 0;
      m_outs.delete();
      m_cycles = 0;
      m_halted = 0;
      while (steps < 200 && m_halted == 0) begin
         ir  = mem[p];
         p   = (p + 1) % 16;
         opc = ir / 16;
         op  = ir % 16;
         steps++;
         case (opc)
            1: begin a = mem[op]; m_cycles += 3; end
            2: begin
               s = a + mem[op];
               c = (s > 255) ? 1 : 0;
               a = s % 256;
               z = (a == 0) ? 1 : 0;
               m_cycles += 3;
            end
            3: begin
               c = (a >= mem[op]) ? 1 : 0;
               a = (a - mem[op] + 256) % 256;
               z = (a == 0) ? 1 : 0;
               m_cycles += 3;
            end
            4: begin mem[op] = a; m_cycles += 2; end
            5: begin a = op; m_cycles += 2; end
            6: begin p = op; m_cycles += 2; end
            7: begin if (c == 1) p = op; m_cycles += 2; end
            8: begin if (z == 1) p = op; m_cycles += 2; end
            14: begin m_outs.push_back(a); m_cycles += 3 + stall; end
            15: begin m_halted = 1; m_cycles += 2; end
            default: m_cycles += 2;
         endcase
      end
      m_pc = p; m_cf = c; m_zf = z;
   endtask

   // Pulse run, then step until HALT, collecting output beats and holding
   // out_ready low for `stall` cycles of every beat.
   task automatic run_prog(input int stall, input int inject, input int limit);
      int wcnt, first_d, first_pc, saw15;
      wcnt = 0; first_d = 0; first_pc = 0; saw15 = 0;
      wrapped = 0;
      got_outs.delete();
      out_ready = 1'b1;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      run_cycles = 0;
      while (!halted && run_cycles < limit) begin
         if (inject >= 0 && run_cycles == inject) begin
            ld_valid = 1'b1;
            ld_addr  = 4'h0;
            ld_data  = 8'h00;
            check("ld_ready_busy", int'(ld_ready), 0);
         end else begin
            ld_valid = 1'b0;
         end
         if (pc == 4'hF) saw15 = 1;
         else begin
            if (saw15 == 1 && pc == 4'h0) wrapped = 1;
            saw15 = 0;
         end
         if (out_valid) begin
            if (wcnt == 0) begin
               first_d  = int'(out_data);
               first_pc = int'(pc);
            end else begin
               check("stall_data", int'(out_data), first_d);
               check("stall_pc", int'(pc), first_pc);
            end
            if (wcnt < stall) begin
               out_ready = 1'b0;
               wcnt++;
            end else begin
               out_ready = 1'b1;
               got_outs.push_back(int'(out_data));
               wcnt = 0;
            end
         end
         @(negedge clk);
         run_cycles++;
      end
      ld_valid  = 1'b0;
      out_ready = 1'b1;
      check("halt_reached", int'(halted), 1);
      check("out_valid_at_halt", int'(out_valid), 0);
   endtask

   vec_t vecs[7];
   int   found, stall, seen;

   initial begin
      clr = 1'b0; run = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_halted", int'(halted), 0);
      check("rst_pc", int'(pc), 0);
      check("rst_flags", int'({cf, zf}), 0);
      check("rst_ld_ready", int'(ld_ready), 1);
      clr = 1'b1;

      // ADD program
      vecs[0] = '{128'h0E1C_0000_0000_0000_0000_0000_F0E0_2F1E, 0, -1, 0,
                  1, 'h2A, 0, 4, 0, 0, 11};
      // carry and zero, JC then JZ taken
      vecs[1] = '{128'h01FF_0000_F0E0_F08A_0000_0000_F078_2F1E, 0, -1, 0,
                  1, 'h00, 0, 12, 1, 1, 15};
      // SUB with borrow
      vecs[2] = '{128'h0700_0000_0000_0000_0000_0000_F0E0_3F55, 0, -1, 0,
                  1, 'hFE, 0, 4, 0, 0, 10};
      // SUB to zero
      vecs[3] = '{128'h0500_0000_0000_0000_0000_0000_F0E0_3F55, 0, -1, 0,
                  1, 'h00, 0, 4, 1, 1, 10};
      // ADD program under 5-cycle backpressure
      vecs[4] = '{128'h0E1C_0000_0000_0000_0000_0000_F0E0_2F1E, 5, -1, 0,
                  1, 'h2A, 0, 4, 0, 0, 16};
      // STA rewrites a later HLT into NOP
      vecs[5] = '{128'h0000_0000_0000_0000_F0E0_F045_E02D_4D53, 0, -1, 0,
                  2, 'h06, 'h06, 8, 0, 0, 19};
      // PC wrap, HLT planted at 0 by STA, ignored load while running
      vecs[6] = '{128'h0000_0000_0000_0000_0000_0000_4011_F062, 0, 10, 1,
                  0, 0, 0, 1, 0, 0, 33};

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 16; i++) load_word(i, int'(vecs[v].prog[i*8 +: 8]));
         run_prog(vecs[v].stall, vecs[v].inject, 100);
         check("vec_n_out", got_outs.size(), vecs[v].n_out);
         for (int i = 0; i < got_outs.size() && i < vecs[v].n_out; i++)
            check("vec_out", got_outs[i], (i == 0) ? vecs[v].out0 : vecs[v].out1);
         check("vec_pc", int'(pc), vecs[v].pc);
         check("vec_cf", int'(cf), vecs[v].cf);
         check("vec_zf", int'(zf), vecs[v].zf);
         check("vec_cycles", run_cycles, vecs[v].cycles);
         if (vecs[v].chk_wrap != 0) check("pc_wrap", wrapped, 1);
      end

      // Random programs against the model.
      for (int t = 0; t < 20; t++) begin
         found = 0;
         stall = 0;
         for (int att = 0; att < 500 && found == 0; att++) begin
            for (int i = 0; i < 16; i++) m_ram[i] = int'($urandom_range(0, 255));
            stall = int'($urandom_range(0, 3));
            model_run(stall);
            found = m_halted;
         end
         check("rand_found", found, 1);
         if (found == 1) begin
            for (int i = 0; i < 16; i++) load_word(i, m_ram[i]);
            run_prog(stall, -1, m_cycles + 20);
            check("rand_n_out", got_outs.size(), m_outs.size());
            for (int i = 0; i < got_outs.size() && i < m_outs.size(); i++)
               check("rand_out", got_outs[i], m_outs[i]);
            check("rand_pc", int'(pc), m_pc);
            check("rand_cf", int'(cf), m_cf);
            check("rand_zf", int'(zf), m_zf);
            check("rand_cycles", run_cycles, m_cycles);
         end
      end

      // Asynchronous reset while an output word is stalled.
      for (int i = 0; i < 16; i++) load_word(i, int'(vecs[0].prog[i*8 +: 8]));
      out_ready = 1'b0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      check("outwait_reached", seen, 1);
      #2 clr = 1'b0;
      #1;
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_idle", int'(ld_ready), 1);
      check("arst_pc", int'(pc), 0);
      check("arst_halted", int'(halted), 0);
      @(negedge clk);
      clr = 1'b1;
      run_prog(0, -1, 60);
      check("rerun_n_out", got_outs.size(), 1);
      if (got_outs.size() > 0) check("rerun_out", got_outs[0], 'h2A);
      check("rerun_cycles", run_cycles, 11);
      check("rerun_pc", int'(pc), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
